// File: rtl/apb_wait_adapter_if.sv
// Bus bundle for apb_wait_adapter: APB3 slave side plus the held-request register interface.
// slave = the adapter's view, master = the environment (interconnect + register block).
interface apb_wait_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_COUNT = (DATA_WIDTH < 8) ? 1 : 2 ** ($clog2(DATA_WIDTH) - 3)
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [BYTE_COUNT-1:0] pstrb;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  logic [ADDR_WIDTH-1:0] rif_addr;
  logic                  rif_addr_valid;
  logic                  rif_wr_req;
  logic                  rif_rd_req;
  logic [BYTE_COUNT-1:0] rif_wstrb;
  logic [DATA_WIDTH-1:0] rif_wdata;
  logic                  rif_ack;
  logic                  rif_err;
  logic [DATA_WIDTH-1:0] rif_rdata;
  logic                  timeout_evt;

  modport slave (
    input  paddr, psel, penable, pwrite, pstrb, pwdata,
    input  rif_addr_valid, rif_ack, rif_err, rif_rdata,
    output prdata, pready, pslverr,
    output rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata, timeout_evt
  );

  modport master (
    output paddr, psel, penable, pwrite, pstrb, pwdata,
    output rif_addr_valid, rif_ack, rif_err, rif_rdata,
    input  prdata, pready, pslverr,
    input  rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata, timeout_evt
  );
endinterface

// File: rtl/apb_wait_adapter.sv
// APB3 slave to register-interface bridge: each access becomes a held request and the
// APB access phase is stretched until the target acks, errors out, or the timeout fires.
module apb_wait_adapter #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          BYTE_EN        = 1'b0,
  parameter bit          REPORT_ERROR   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned BYTE_COUNT     = (DATA_WIDTH < 8) ? 1 : 2 ** ($clog2(DATA_WIDTH) - 3)
) (
  input logic                pclk,
  input logic                presetn,
  apb_wait_adapter_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTE_COUNT-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_wr_req;
  logic                  r_rd_req;
  logic                  r_tmo_evt;
  logic                  w_timeout;

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_tmo_evt <= 1'b0;
    end else begin
      r_tmo_evt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.psel && !bus.penable) begin
            r_addr  <= bus.paddr;
            r_write <= bus.pwrite;
            r_cnt   <= '0;
            if (bus.pwrite) begin
              r_wdata <= bus.pwdata;
              r_wstrb <= BYTE_EN ? bus.pstrb : '1;
            end else begin
              r_wstrb <= '0;
            end
            // Undecoded address: answer straight away, never touch the target.
            if (!bus.rif_addr_valid) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= REPORT_ERROR;
            end else begin
              r_state  <= S_WAIT;
              r_wr_req <= bus.pwrite;
              r_rd_req <= !bus.pwrite;
            end
          end
        end

        S_WAIT: begin
          if (!bus.psel) begin
            r_state  <= S_IDLE;
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
          end else if (bus.rif_ack) begin
            // Ack takes priority over a timeout landing in the same cycle.
            r_state   <= S_RESP;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= bus.rif_err & REPORT_ERROR;
            if (!r_write) begin
              r_prdata <= bus.rif_err ? '0 : bus.rif_rdata;
            end
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= REPORT_ERROR;
            r_tmo_evt <= 1'b1;
            if (!r_write) begin
              r_prdata <= '0;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (!bus.psel || bus.penable) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_pready <= 1'b0;
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prdata      = r_prdata;
  assign bus.pready      = r_pready;
  assign bus.pslverr     = r_pslverr;
  assign bus.rif_addr    = r_addr;
  assign bus.rif_wr_req  = r_wr_req;
  assign bus.rif_rd_req  = r_rd_req;
  assign bus.rif_wstrb   = r_wstrb;
  assign bus.rif_wdata   = r_wdata;
  assign bus.timeout_evt = r_tmo_evt;

endmodule
